id_exe_elastic_reg: RTL
=======================

Name: id_exe_elastic_reg

Overview:
- Parametrised successor of the ID/EXE pipeline register.
- Adds a valid/ready handshake with a 2-entry skid buffer, so the ID-side ready is a registered signal with no combinational path from exe_ready.
- Adds a synchronous flush for branch/exception squash.
- The ALU-control and illegal-instruction decode happen on the ID side and are registered, so EXE sees a flop output.
- Sits between the decoder/regfile read stage and the ALU/memory-address stage.

Parameters:
- DATA_W, 32, width of PC, operands, immediate, rt data and memory address.
- REG_ADDR_W, 5, GPR write-address width.
- ALU_CTRL_W, 4, ALU control width; must be >= 4.
- SKID_EN, 1, 1 = 2-entry skid buffer; 0 = single register with id_ready = ~exe_valid | exe_ready.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- flush  in  1  squash all held and incoming entries
- id_valid  in  1  ID offers an instruction
- id_ready  out  1  stage can accept
- id_instr  in  32  instruction word
- id_pc  in  DATA_W  instruction PC
- id_ext_result  in  DATA_W  extended immediate / shamt
- id_rs_data  in  DATA_W  regfile rs read
- id_rt_data  in  DATA_W  regfile rt read
- id_gpr_we  in  1  writeback enable
- id_gpr_waddr  in  REG_ADDR_W  writeback address
- id_gpr_wdata_select  in  2  writeback mux select
- id_mem_addr  in  DATA_W  precomputed memory address
- exe_ready  in  1  EXE consumes the entry
- exe_valid  out  1  entry valid
- exe_alu_opr1  out  DATA_W  ALU operand 1
- exe_alu_opr2  out  DATA_W  ALU operand 2
- exe_alu_control  out  ALU_CTRL_W  ALU op
- exe_illegal  out  1  undecodable instruction
- exe_mem_fetch_addr  out  DATA_W  memory address
- exe_gpr_we  out  1  writeback enable, already qualified by valid
- exe_gpr_waddr  out  REG_ADDR_W  writeback address
- exe_gpr_wdata_select  out  2  writeback select
- exe_gpr_rt  out  DATA_W  rt data for stores/movz/movn
- exe_pc  out  DATA_W  PC
- exe_instr  out  32  instruction word

Behaviour:
- **Clock and reset.** Single clock; reset is asynchronous, active-high. On reset every output, every skid entry and every valid bit is 0. The reset value of exe_alu_control is 0.
- **Operand select** (computed at ID):
  - opr1 = ext when instr[29:26]==0 && instr[5]==0 && instr[3]==0 && instr[2]==0 (sll/srl/sra); otherwise rs.
  - opr2 = ext when instr[29] | instr[31]; otherwise rt.
- **ALU decode, R-type** (opcode 000000):
  - add 0010, addu 0011, sub 0100, subu 0101, and 0110, or 0111, xor 1000, nor 1001, slt 1010, sltu 1011.
  - sll/sllv 1110, srl/srlv 1100, sra/srav 1101, movz 0000, movn 0001.
  - Any other funct gives 0000 with illegal=1.
- **ALU decode, I-type and memory:**
  - addi 0010; lw/sw/addiu 0011; andi 0110; ori 0111; xori 1000; slti 1010; sltiu 1011; lui 1111.
  - beq/bne/j/jal give 0110 with illegal=0.
  - Any other opcode gives 0110 with illegal=1.
- **Width rule.** Codes are zero-extended when ALU_CTRL_W > 4.
- **Handshake.**
  - Transfer in when id_valid && id_ready.
  - Transfer out when exe_valid && exe_ready.
  - Latency is 1 cycle from input transfer to exe_valid.
  - Throughput is 1 per cycle while exe_ready=1.
- **Skid state machine** (SKID_EN=1):
  - States: EMPTY (exe_valid=0), ONE (main valid), FULL (main + skid valid).
  - id_ready = (state != FULL); it is a flop output.
  - EMPTY: input transfer goes to ONE and loads main.
  - ONE:
    - in and out together: stay in ONE, reload main.
    - in only: go to FULL, load skid.
    - out only: go to EMPTY.
  - FULL (no input possible): on out, go to ONE; main <= skid.
- **Valid qualification.** exe_gpr_we = stored gpr_we & valid. When exe_valid=0, exe_gpr_we must read 0 in all states.
- **Output stability.** Outputs hold stable while exe_valid && !exe_ready.
- **Flush.**
  - Next state is EMPTY and exe_valid=0 next cycle.
  - Any same-cycle input transfer is dropped.
  - Flush has priority over all transfers.
  - Data fields are not cleared, except that gpr_we is forced to 0.
- **Reset mid-transfer.** Asynchronous reset overrides everything, including an in-flight FULL state.
- **SKID_EN=0.** Two states only (EMPTY/ONE). id_ready is combinational from exe_ready.

Decomposition:
- Shared package `cpu_pkg`:
  - ALU code localparams (ALU_MOVZ … ALU_LUI).
  - Opcode and funct localparams.
  - Skid state encoding.
- One natural sub-module: `alu_ctrl_decode`. It is purely combinational: instr in, {alu_control, illegal, opr1_sel, opr2_sel} out, and is instantiated on the ID side.

Test Plan:
- **Reset:** hold reset=1 during traffic -> all outputs 0 and id_ready=0. Release reset -> next cycle id_ready=1, exe_valid=0.
- **Streaming:** exe_ready=1; send addu $3,$1,$2 (instr 0x00221821, rs=5, rt=7), then sll (0x00021080, ext=2) -> cycle+1: control 0011, opr1=5, opr2=7. Cycle+2: control 1110, opr1=2, opr2=rt.
- **Backpressure:** exe_ready=0; send 3 instructions -> entry 1 held in main, entry 2 in skid, id_ready=0 by cycle 3, entry 3 stalled. Raise exe_ready -> entries delivered in order 1, 2, 3 with no loss or duplication.
- **Flush in FULL:** flush while FULL with a concurrent id_valid -> next cycle exe_valid=0 and exe_gpr_we=0. The flushed-cycle input never appears.
- **Illegal decode:** send opcode 0x3F -> control 0110, illegal=1. Send funct 0x3F -> control 0000, illegal=1. Send lui -> control 1111, opr2=ext.
- **Immediate operand and gating:** send sw (opcode 101011) -> control 0011, opr2=ext, exe_gpr_rt=rt data. With id_gpr_we=1 while exe_valid=0, exe_gpr_we=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the ID/EXE elastic pipeline register.
//   - ALU control codes (4-bit base encoding, zero-extended by users
//     whose control bus is wider)
//   - MIPS opcode and R-type funct field values used by the decoder
//   - skid-buffer state encoding
package cpu_pkg;

  // ALU control codes
  localparam logic [3:0] ALU_MOVZ = 4'b0000;
  localparam logic [3:0] ALU_MOVN = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_ADDU = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_SUBU = 4'b0101;
  localparam logic [3:0] ALU_AND  = 4'b0110;
  localparam logic [3:0] ALU_OR   = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_NOR  = 4'b1001;
  localparam logic [3:0] ALU_SLT  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_SRL  = 4'b1100;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_SLL  = 4'b1110;
  localparam logic [3:0] ALU_LUI  = 4'b1111;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_MOVZ = 6'b001010;
  localparam logic [5:0] FN_MOVN = 6'b001011;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  // Skid-buffer occupancy: EMPTY (nothing held), ONE (main valid),
  // FULL (main + skid valid)
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/id_exe_elastic_reg_if.sv
// Bundle of the ID-side and EXE-side signals of the ID/EXE elastic register.
//   slave  : the pipeline register itself (consumes id_*, exe_ready;
//            produces id_ready, exe_*, dbg_state)
//   master : the surrounding pipeline / environment (opposite directions)
//
// Handshake: a beat moves on a rising clock edge where valid && ready are
// both 1. A producer holding valid may not withdraw or change its payload
// until the beat moves; ready may change freely.
interface id_exe_elastic_reg_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_CTRL_W = 4
) ();
  import cpu_pkg::*;

  // ID side
  logic                  id_valid;
  logic                  id_ready;
  logic [31:0]           id_instr;
  logic [DATA_W-1:0]     id_pc;
  logic [DATA_W-1:0]     id_ext_result;
  logic [DATA_W-1:0]     id_rs_data;
  logic [DATA_W-1:0]     id_rt_data;
  logic                  id_gpr_we;
  logic [REG_ADDR_W-1:0] id_gpr_waddr;
  logic [1:0]            id_gpr_wdata_select;
  logic [DATA_W-1:0]     id_mem_addr;

  // EXE side
  logic                  exe_ready;
  logic                  exe_valid;
  logic [DATA_W-1:0]     exe_alu_opr1;
  logic [DATA_W-1:0]     exe_alu_opr2;
  logic [ALU_CTRL_W-1:0] exe_alu_control;
  logic                  exe_illegal;
  logic [DATA_W-1:0]     exe_mem_fetch_addr;
  logic                  exe_gpr_we;
  logic [REG_ADDR_W-1:0] exe_gpr_waddr;
  logic [1:0]            exe_gpr_wdata_select;
  logic [DATA_W-1:0]     exe_gpr_rt;
  logic [DATA_W-1:0]     exe_pc;
  logic [31:0]           exe_instr;

  // FSM observation
  skid_state_e           dbg_state;

  modport slave (
    input  id_valid, id_instr, id_pc, id_ext_result, id_rs_data, id_rt_data,
           id_gpr_we, id_gpr_waddr, id_gpr_wdata_select, id_mem_addr,
           exe_ready,
    output id_ready, exe_valid, exe_alu_opr1, exe_alu_opr2, exe_alu_control,
           exe_illegal, exe_mem_fetch_addr, exe_gpr_we, exe_gpr_waddr,
           exe_gpr_wdata_select, exe_gpr_rt, exe_pc, exe_instr, dbg_state
  );

  modport master (
    output id_valid, id_instr, id_pc, id_ext_result, id_rs_data, id_rt_data,
           id_gpr_we, id_gpr_waddr, id_gpr_wdata_select, id_mem_addr,
           exe_ready,
    input  id_ready, exe_valid, exe_alu_opr1, exe_alu_opr2, exe_alu_control,
           exe_illegal, exe_mem_fetch_addr, exe_gpr_we, exe_gpr_waddr,
           exe_gpr_wdata_select, exe_gpr_rt, exe_pc, exe_instr, dbg_state
  );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU-control / operand-select decoder on the ID side.
//   instr       in  32  instruction word
//   alu_control out 4   ALU op code (cpu_pkg ALU_*)
//   illegal     out 1   opcode / funct not recognised
//   opr1_sel    out 1   1 = operand 1 takes the extended immediate (shamt)
//   opr2_sel    out 1   1 = operand 2 takes the extended immediate
module alu_ctrl_decode
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  alu_control,
  output logic        illegal,
  output logic        opr1_sel,
  output logic        opr2_sel
);

  logic [5:0] opcode;
  logic [5:0] funct;
  // Register-number / immediate fields play no part in the decode.
  logic       unused_instr_bits;

  assign opcode            = instr[31:26];
  assign funct             = instr[5:0];
  assign unused_instr_bits = ^instr[25:6];

  // Shift-by-shamt forms (sll/srl/sra) feed the shamt through operand 1.
  assign opr1_sel = (instr[29:26] == 4'd0) && !instr[5] && !instr[3] && !instr[2];
  // I-type ALU ops (bit 29) and loads/stores (bit 31) use the immediate.
  assign opr2_sel = instr[29] | instr[31];

  always_comb begin
    alu_control = ALU_AND;
    illegal     = 1'b0;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_ADD:          alu_control = ALU_ADD;
        FN_ADDU:         alu_control = ALU_ADDU;
        FN_SUB:          alu_control = ALU_SUB;
        FN_SUBU:         alu_control = ALU_SUBU;
        FN_AND:          alu_control = ALU_AND;
        FN_OR:           alu_control = ALU_OR;
        FN_XOR:          alu_control = ALU_XOR;
        FN_NOR:          alu_control = ALU_NOR;
        FN_SLT:          alu_control = ALU_SLT;
        FN_SLTU:         alu_control = ALU_SLTU;
        FN_SLL, FN_SLLV: alu_control = ALU_SLL;
        FN_SRL, FN_SRLV: alu_control = ALU_SRL;
        FN_SRA, FN_SRAV: alu_control = ALU_SRA;
        FN_MOVZ:         alu_control = ALU_MOVZ;
        FN_MOVN:         alu_control = ALU_MOVN;
        default: begin
          alu_control = ALU_MOVZ;
          illegal     = 1'b1;
        end
      endcase
    end else begin
      case (opcode)
        OP_ADDI:                    alu_control = ALU_ADD;
        OP_LW, OP_SW, OP_ADDIU:     alu_control = ALU_ADDU;
        OP_ANDI:                    alu_control = ALU_AND;
        OP_ORI:                     alu_control = ALU_OR;
        OP_XORI:                    alu_control = ALU_XOR;
        OP_SLTI:                    alu_control = ALU_SLT;
        OP_SLTIU:                   alu_control = ALU_SLTU;
        OP_LUI:                     alu_control = ALU_LUI;
        // Control transfers are resolved elsewhere; the ALU result is unused.
        OP_BEQ, OP_BNE, OP_J, OP_JAL: alu_control = ALU_AND;
        default: begin
          alu_control = ALU_AND;
          illegal     = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/id_exe_elastic_reg.sv
// ID/EXE pipeline register with valid/ready handshake, optional 2-entry
// skid buffer and synchronous flush.
//   clk    in   clock
//   reset  in   asynchronous active-high reset
//   flush  in   squash held and same-cycle incoming entries
//   bus    slave modport of id_exe_elastic_reg_if (ID inputs, EXE outputs,
//          dbg_state)
// Decode (ALU control, illegal, operand selects) is done from the ID-side
// instruction and registered, so every EXE output is a flop (exe_gpr_we is
// a flop ANDed with the registered valid).
module id_exe_elastic_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_CTRL_W = 4,
  parameter bit SKID_EN    = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  input logic                 flush,
  id_exe_elastic_reg_if.slave bus
);

  // Stored entry layout (gpr_we is kept apart so flush can clear it alone):
  // {opr1, opr2, alu_ctrl, illegal, mem_addr, waddr, wsel, rt, pc, instr}
  localparam int PAY_W = 5 * DATA_W + ALU_CTRL_W + 1 + REG_ADDR_W + 2 + 32;

  logic [3:0]            dec_ctrl;
  logic                  dec_illegal;
  logic                  dec_opr1_sel;
  logic                  dec_opr2_sel;
  logic [DATA_W-1:0]     opr1_in;
  logic [DATA_W-1:0]     opr2_in;
  logic [ALU_CTRL_W-1:0] ctrl_in;
  logic [PAY_W-1:0]      in_pay;

  skid_state_e           state;
  logic [PAY_W-1:0]      main_q;
  logic [PAY_W-1:0]      skid_q;
  logic                  main_we_q;
  logic                  skid_we_q;
  logic                  rdy_q;

  logic                  exe_valid_w;
  logic                  in_xfer;
  logic                  out_xfer;

  alu_ctrl_decode u_dec (
    .instr       (bus.id_instr),
    .alu_control (dec_ctrl),
    .illegal     (dec_illegal),
    .opr1_sel    (dec_opr1_sel),
    .opr2_sel    (dec_opr2_sel)
  );

  assign opr1_in = dec_opr1_sel ? bus.id_ext_result : bus.id_rs_data;
  assign opr2_in = dec_opr2_sel ? bus.id_ext_result : bus.id_rt_data;
  assign ctrl_in = ALU_CTRL_W'(dec_ctrl);

  assign in_pay = {opr1_in, opr2_in, ctrl_in, dec_illegal, bus.id_mem_addr,
                   bus.id_gpr_waddr, bus.id_gpr_wdata_select, bus.id_rt_data,
                   bus.id_pc, bus.id_instr};

  assign exe_valid_w = (state != ST_EMPTY);

  // With the skid buffer, ready is a flop (state != FULL) so there is no
  // combinational path from exe_ready. Without it, ready looks through.
  assign bus.id_ready = SKID_EN ? rdy_q : (~exe_valid_w | bus.exe_ready);

  assign in_xfer  = bus.id_valid & bus.id_ready;
  assign out_xfer = exe_valid_w & bus.exe_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      main_we_q <= 1'b0;
      skid_we_q <= 1'b0;
      rdy_q     <= 1'b0;
    end else if (flush) begin
      // Payload is left as-is; only the write enables are squashed.
      state     <= ST_EMPTY;
      main_we_q <= 1'b0;
      skid_we_q <= 1'b0;
      rdy_q     <= 1'b1;
    end else begin
      rdy_q <= 1'b1;
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_q    <= in_pay;
            main_we_q <= bus.id_gpr_we;
            state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_q    <= in_pay;
            main_we_q <= bus.id_gpr_we;
          end else if (in_xfer) begin
            // Only reachable with SKID_EN: main is stalled, park the new beat.
            skid_q    <= in_pay;
            skid_we_q <= bus.id_gpr_we;
            state     <= ST_FULL;
            rdy_q     <= 1'b0;
          end else if (out_xfer) begin
            main_we_q <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            main_q    <= skid_q;
            main_we_q <= skid_we_q;
            skid_we_q <= 1'b0;
            state     <= ST_ONE;
          end else begin
            rdy_q <= 1'b0;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          main_we_q <= 1'b0;
          skid_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign {bus.exe_alu_opr1, bus.exe_alu_opr2, bus.exe_alu_control,
          bus.exe_illegal, bus.exe_mem_fetch_addr, bus.exe_gpr_waddr,
          bus.exe_gpr_wdata_select, bus.exe_gpr_rt, bus.exe_pc,
          bus.exe_instr} = main_q;

  assign bus.exe_valid  = exe_valid_w;
  assign bus.exe_gpr_we = main_we_q & exe_valid_w;
  assign bus.dbg_state  = state;

endmodule
